// File: rtl/eth_tx_framer.sv
// Ethernet II transmit framer: wraps a payload byte stream with preamble, SFD, fixed header,
// zero padding and CRC-32 FCS, then holds off for the inter-frame gap.
module eth_tx_framer #(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter int unsigned IFG_CYCLES  = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_byte,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       frame_start,
  output logic       frame_done,
  output logic       busy,
  output logic       err_oversize
);

  typedef enum logic [3:0] {
    StIdle, StPreamble, StSfd, StHeader, StPayload, StPad, StFcs, StIfg, StDrain
  } state_e;

  localparam logic [111:0] Header  = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [10:0]  MinPay  = 11'(MIN_PAYLOAD);
  localparam logic [10:0]  MaxPay  = 11'(MAX_PAYLOAD);
  localparam logic [15:0]  IfgLast = 16'(IFG_CYCLES - 1);

  state_e      state;
  logic [3:0]  idx;
  logic [10:0] pay_cnt;
  logic [15:0] ifg_cnt;
  logic [31:0] crc;
  logic        drain_pending;

  logic        load_en;
  logic [10:0] pay_inc;
  logic [7:0]  hdr_byte;
  logic [7:0]  fcs_byte;

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign load_en = !tx_valid || tx_ready;
  assign s_ready = ((state == StPayload) && load_en) || (state == StDrain);
  assign pay_inc = pay_cnt + 11'd1;
  assign busy    = (state != StIdle);

  always_comb begin
    hdr_byte = 8'h00;
    for (int i = 0; i < 14; i++) begin
      if (idx == 4'(i)) hdr_byte = Header[8*(13-i) +: 8];
    end
  end

  // FCS goes out least-significant byte first.
  always_comb begin
    fcs_byte = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (idx == 4'(i)) fcs_byte = ~crc[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= StIdle;
      tx_byte       <= 8'h00;
      tx_valid      <= 1'b0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
      err_oversize  <= 1'b0;
      idx           <= 4'd0;
      pay_cnt       <= 11'd0;
      ifg_cnt       <= 16'd0;
      crc           <= 32'hFFFF_FFFF;
      drain_pending <= 1'b0;
    end else begin
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      err_oversize <= 1'b0;
      unique case (state)
        StIdle: begin
          if (s_valid) begin
            tx_byte       <= 8'h55;
            tx_valid      <= 1'b1;
            frame_start   <= 1'b1;
            idx           <= 4'd1;
            pay_cnt       <= 11'd0;
            crc           <= 32'hFFFF_FFFF;
            drain_pending <= 1'b0;
            state         <= StPreamble;
          end
        end
        StPreamble: begin
          if (load_en) begin
            tx_byte  <= 8'h55;
            tx_valid <= 1'b1;
            idx      <= idx + 4'd1;
            if (idx == 4'd6) begin
              idx   <= 4'd0;
              state <= StSfd;
            end
          end
        end
        StSfd: begin
          if (load_en) begin
            tx_byte  <= 8'hD5;
            tx_valid <= 1'b1;
            state    <= StHeader;
          end
        end
        StHeader: begin
          if (load_en) begin
            tx_byte  <= hdr_byte;
            tx_valid <= 1'b1;
            crc      <= crc_step(crc, hdr_byte);
            idx      <= idx + 4'd1;
            if (idx == 4'd13) begin
              idx   <= 4'd0;
              state <= StPayload;
            end
          end
        end
        StPayload: begin
          if (load_en) begin
            // No filler on input gaps: the slot simply empties.
            tx_valid <= s_valid;
            if (s_valid) begin
              tx_byte <= s_byte;
              crc     <= crc_step(crc, s_byte);
              pay_cnt <= pay_inc;
              if (s_last) begin
                state <= (pay_inc < MinPay) ? StPad : StFcs;
              end else if (pay_inc == MaxPay) begin
                err_oversize  <= 1'b1;
                drain_pending <= 1'b1;
                state         <= StFcs;
              end
            end
          end
        end
        StPad: begin
          if (load_en) begin
            tx_byte  <= 8'h00;
            tx_valid <= 1'b1;
            crc      <= crc_step(crc, 8'h00);
            pay_cnt  <= pay_inc;
            if (pay_inc >= MinPay) state <= StFcs;
          end
        end
        StFcs: begin
          if (load_en) begin
            tx_byte  <= fcs_byte;
            tx_valid <= 1'b1;
            idx      <= idx + 4'd1;
            if (idx == 4'd3) begin
              idx     <= 4'd0;
              ifg_cnt <= 16'd0;
              state   <= drain_pending ? StDrain : StIfg;
            end
          end
        end
        StDrain: begin
          if (tx_valid && tx_ready) begin
            tx_valid   <= 1'b0;
            frame_done <= 1'b1;
          end
          if (s_valid && s_last) begin
            ifg_cnt <= 16'd0;
            state   <= StIfg;
          end
        end
        StIfg: begin
          // Gap counting starts only once the last FCS byte has left the slot.
          if (tx_valid) begin
            if (tx_ready) begin
              tx_valid   <= 1'b0;
              frame_done <= 1'b1;
              ifg_cnt    <= 16'd0;
            end
          end else if (ifg_cnt == IfgLast) begin
            ifg_cnt <= 16'd0;
            state   <= StIdle;
          end else begin
            ifg_cnt <= ifg_cnt + 16'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: frame contents, FCS residue, timing, stalls, oversize, reset.
module tb_eth_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_byte = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       frame_start, frame_done, busy, err_oversize;

  logic ready_mode = 1'b0;
  logic rnd_bit = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   stab_err = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  logic [7:0] cap[$];
  int         cap_cyc[$];
  int         fs_cyc[$];
  int         fd_cyc[$];
  int         err_cyc[$];
  logic [7:0] pay[$];
  logic [7:0] exp_q[$];
  logic [7:0] hdr_bytes [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                                 8'h88, 8'hB5};

  eth_tx_framer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_byte       (s_byte),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .tx_byte      (tx_byte),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .busy         (busy),
    .err_oversize (err_oversize)
  );

  always #5 clk = ~clk;

  assign tx_ready = ready_mode ? rnd_bit : 1'b1;

  always @(posedge clk) begin
    cyc++;
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  // Observe on the falling edge: a valid&&ready here is taken by the next rising edge.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      cap.push_back(tx_byte);
      cap_cyc.push_back(cyc);
    end
    if (prev_stall && (tx_byte !== prev_byte)) stab_err++;
    prev_stall = tx_valid && !tx_ready;
    prev_byte  = tx_byte;
    if (frame_start)  fs_cyc.push_back(cyc);
    if (frame_done)   fd_cyc.push_back(cyc);
    if (err_oversize) err_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int j = 0; j < 8; j++) begin
      fb = r[0] ^ d[j];
      r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0);
    end
    return r;
  endfunction

  task automatic append_frame(input int npay);
    logic [31:0] c;
    logic [7:0]  b;
    int          total;
    c     = 32'hFFFF_FFFF;
    total = (npay < 46) ? 46 : npay;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 14; i++) begin
      b = hdr_bytes[i];
      exp_q.push_back(b);
      c = crc_bits(c, b);
    end
    for (int i = 0; i < total; i++) begin
      b = (i < npay) ? pay[i] : 8'h00;
      exp_q.push_back(b);
      c = crc_bits(c, b);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(c[7:0]);
      c = c >> 8;
    end
  endtask

  task automatic clear_all();
    cap.delete(); cap_cyc.delete(); fs_cyc.delete(); fd_cyc.delete(); err_cyc.delete();
    exp_q.delete(); pay.delete();
  endtask

  task automatic send(input bit gaps, input int stop_at);
    int   i = 0;
    int   guard = 0;
    logic acc;
    while ((i < pay.size()) && (i != stop_at) && (guard < 20000)) begin
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_byte  = pay[i];
      s_last  = (i == pay.size() - 1);
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_byte  = 8'h00;
    chk("send_count", i, (stop_at < 0) ? pay.size() : stop_at);
  endtask

  task automatic wait_idle(input string tag, output int t);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (busy && (g < 5000));
    t = cyc;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_frames(input string tag);
    int mism = 0;
    int n;
    chk({tag, "_len"}, cap.size(), exp_q.size());
    n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (cap[i] !== exp_q[i]) mism++;
    chk({tag, "_bytes"}, mism, 0);
  endtask

  // Running CRC over DST..FCS of a correct frame leaves the fixed residue.
  task automatic residue(input string tag, input int start, input int len);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = start + 8; (i < start + len) && (i < cap.size()); i++) c = crc_bits(c, cap[i]);
    chk(tag, c, 32'hDEBB_20E3);
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int t0, t_idle;

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", {29'd0, frame_start, frame_done, err_oversize}, 32'd0);
    @(posedge clk);
    #1;

    // 1-byte payload, full rate: 72 beats with padding, exact timing
    clear_all();
    pay.push_back(8'hAB);
    append_frame(1);
    t0 = cyc;
    send(1'b0, -1);
    wait_idle("one", t_idle);
    compare_frames("one");
    residue("one_residue", 0, 72);
    chk("one_sfd", 32'(cap.size() > 7 ? cap[7] : 8'h00), 32'hD5);
    chk("one_payload", 32'(cap.size() > 22 ? cap[22] : 8'h00), 32'hAB);
    chk("one_pad", 32'(cap.size() > 67 ? cap[67] : 8'hFF), 32'h00);
    chk("one_fs_cycle", at(fs_cyc, 0) - t0, 1);
    chk("one_first_pay_lat", at(cap_cyc, 22) - at(fs_cyc, 0), 22);
    chk("one_no_gaps", at(cap_cyc, 71) - at(cap_cyc, 0), 71);
    chk("one_fd_cycle", at(fd_cyc, 0) - at(cap_cyc, 71), 1);
    chk("one_ifg", t_idle - at(fd_cyc, 0), 12);

    // 46-byte payload: no padding
    clear_all();
    for (int i = 0; i < 46; i++) pay.push_back(8'(i));
    append_frame(46);
    send(1'b0, -1);
    wait_idle("min", t_idle);
    compare_frames("min");
    residue("min_residue", 0, 72);
    chk("min_fd_count", fd_cyc.size(), 1);

    // 60-byte payload with random backpressure and input gaps
    clear_all();
    for (int i = 0; i < 60; i++) pay.push_back(8'((i * 7 + 3) & 8'hFF));
    append_frame(60);
    stab_err   = 0;
    ready_mode = 1'b1;
    send(1'b1, -1);
    wait_idle("stall", t_idle);
    ready_mode = 1'b0;
    compare_frames("stall");
    residue("stall_residue", 0, 86);
    chk("stall_stable", stab_err, 0);

    // Oversize: 1510 bytes, s_last only on the last one
    clear_all();
    for (int i = 0; i < 1510; i++) pay.push_back(8'(i));
    append_frame(1500);
    send(1'b0, -1);
    wait_idle("over", t_idle);
    compare_frames("over");
    residue("over_residue", 0, 1526);
    chk("over_err_count", err_cyc.size(), 1);
    chk("over_err_cycle", at(err_cyc, 0), at(cap_cyc, 1521));
    chk("over_fd_count", fd_cyc.size(), 1);

    // Back-to-back 10-byte frames: gap from frame_done to next frame_start
    clear_all();
    for (int i = 0; i < 10; i++) pay.push_back(8'(8'h10 + i));
    append_frame(10);
    append_frame(10);
    send(1'b0, -1);
    send(1'b0, -1);
    wait_idle("b2b", t_idle);
    compare_frames("b2b");
    residue("b2b_residue2", 72, 72);
    chk("b2b_fs_count", fs_cyc.size(), 2);
    chk("b2b_gap", at(fs_cyc, 1) - at(fd_cyc, 0), 13);

    // Reset in the middle of the payload, then a clean frame
    clear_all();
    for (int i = 0; i < 60; i++) pay.push_back(8'hEE);
    send(1'b0, 10);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pulses", {29'd0, frame_start, frame_done, err_oversize}, 32'd0);
    @(posedge clk);
    #1;
    clear_all();
    for (int i = 0; i < 5; i++) pay.push_back(8'(8'hC0 + i));
    append_frame(5);
    send(1'b0, -1);
    wait_idle("post", t_idle);
    compare_frames("post");
    residue("post_residue", 0, 72);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
